// File: rtl/dbg_uart_pkg.sv
// rtl/dbg_uart_pkg.sv - shared types and constants for the debugger UART receive path
package dbg_uart_pkg;

  // RX_PARITY is only reachable when PARITY_EN is defined; RX_BREAK waits out a low stop bit
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART byte receiver (8N1, or 8E1 when PARITY_EN is defined)
module uart_rx_byte
  import dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err_p,
  output logic       parity_err_p
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             ferr_q, ferr_d;
`ifdef PARITY_EN
  logic             perr_pend_q, perr_pend_d;
  logic             perr_q, perr_d;
`endif

  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= UART_IDLE_LEVEL;
      sync2_q <= UART_IDLE_LEVEL;
      prev_q  <= UART_IDLE_LEVEL;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // receiver state, baud counter, shift register and registered pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef PARITY_EN
      perr_pend_q  <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
`ifdef PARITY_EN
      perr_pend_q  <= perr_pend_d;
      perr_q       <= perr_d;
`endif
    end
  end

  // frame sequencing: sample mid-bit, start bit checked at half a bit time
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
`ifdef PARITY_EN
    perr_pend_d  = perr_pend_q;
    perr_d       = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q == UART_IDLE_LEVEL && sync2_q != UART_IDLE_LEVEL) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
`ifdef PARITY_EN
          perr_pend_d = 1'b0;
`endif
          state_d = (sync2_q == UART_IDLE_LEVEL) ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      RX_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d       = '0;
          perr_pend_d = ^{shreg_q, sync2_q};
          state_d     = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
`ifdef PARITY_EN
          perr_d = perr_pend_q;
          byte_valid_d = sync2_q && !perr_pend_q;
`else
          byte_valid_d = sync2_q;
`endif
          if (sync2_q == UART_IDLE_LEVEL) begin
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (sync2_q == UART_IDLE_LEVEL) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_data   = shreg_q;
  assign byte_valid  = byte_valid_q;
  assign frame_err_p = ferr_q;
`ifdef PARITY_EN
  assign parity_err_p = perr_q;
`else
  assign parity_err_p = 1'b0;
`endif

endmodule

// File: rtl/uart_vector_unpacker.sv
// rtl/uart_vector_unpacker.sv - rebuilds N-lane vectors from the debugger UART byte stream (PARITY_EN selects 8E1)
module uart_vector_unpacker
  import dbg_uart_pkg::*;
#(
  parameter int N            = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    flush,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    overflow,
  output logic                    frame_err,
  output logic                    parity_err
);

  localparam int VW     = N * DATA_WIDTH;
  localparam int BPW    = bytes_per_word(DATA_WIDTH);
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BPW - 1);

  logic [7:0]        byte_data;
  logic              byte_valid, frame_err_p, parity_err_p;

  logic [VW-1:0]     asm_q, asm_d;
  logic [VW-1:0]     out_q, out_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              held_q, held_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, perr_q;
  logic              out_free, last_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .uart_rxd    (uart_rxd),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_err_p (frame_err_p),
    .parity_err_p(parity_err_p)
  );

  // output register can take a new vector this cycle when empty or being drained
  assign out_free  = !valid_q || ready_in;
  assign last_byte = (lane_cnt_q == LANE_LAST) && (byte_cnt_q == BYTE_LAST);

  // assembly, held-vector and output register state
  always_ff @(posedge clk) begin
    if (!reset) begin
      asm_q      <= '0;
      out_q      <= '0;
      lane_cnt_q <= '0;
      byte_cnt_q <= '0;
      held_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      out_q      <= out_d;
      lane_cnt_q <= lane_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      held_q     <= held_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // sticky line-error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_q | frame_err_p;
      perr_q <= perr_q | parity_err_p;
    end
  end

  // byte placement, vector completion, back-pressure and flush handling
  always_comb begin
    asm_d      = asm_q;
    out_d      = out_q;
    lane_cnt_d = lane_cnt_q;
    byte_cnt_d = byte_cnt_q;
    held_d     = held_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;

    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end

    if (flush) begin
      lane_cnt_d = '0;
      byte_cnt_d = '0;
      held_d     = 1'b0;
    end else begin
      // a held vector moves out as soon as the output frees up
      if (held_q && out_free) begin
        out_d   = asm_q;
        valid_d = 1'b1;
        held_d  = 1'b0;
      end

      if (byte_valid && held_q && !out_free) begin
        ovf_d = 1'b1;
      end else if (byte_valid) begin
        for (int k = 0; k < N; k++) begin
          for (int b = 0; b < BPW; b++) begin
            if (lane_cnt_q == LANE_W'(k) && byte_cnt_q == BYTE_W'(b)) begin
              asm_d[k*DATA_WIDTH + 8*b +: 8] = byte_data;
            end
          end
        end
        if (byte_cnt_q == BYTE_LAST) begin
          byte_cnt_d = '0;
          lane_cnt_d = (lane_cnt_q == LANE_LAST) ? '0 : lane_cnt_q + 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (last_byte) begin
          if (out_free && !held_q) begin
            out_d   = asm_d;
            valid_d = 1'b1;
          end else begin
            held_d = 1'b1;
          end
        end
      end
    end
  end

  assign vector_out = out_q;
  assign valid_out  = valid_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_vector_unpacker.sv
// tb/tb_uart_vector_unpacker.sv - scoreboard bench for uart_vector_unpacker (PARITY_EN adds the parity case)
module tb_uart_vector_unpacker;

  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int CPB = 8;
  localparam int VW  = N * DW;
  localparam int BYTES_PER_VEC = VW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uart_rxd = 1'b1;
  logic          flush = 1'b0;
  logic          ready_in = 1'b0;
  logic [VW-1:0] vector_out;
  logic          valid_out, overflow, frame_err, parity_err;

  int compared = 0;
  int mismatched = 0;

  logic [VW-1:0] exp_q[$];
  logic [7:0]    part_q[$];
  logic [VW-1:0] mon_exp;
  logic [VW-1:0] first_vec, second_vec;
  bit            exp_ovf = 1'b0;
  bit            exp_ferr = 1'b0;
  bit            exp_perr = 1'b0;

  always #5 clk = ~clk;

  uart_vector_unpacker #(
    .N(N),
    .DATA_WIDTH(DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .flush     (flush),
    .vector_out(vector_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overflow  (overflow),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: bytes are concatenated little-endian lane by lane; with the output
  // and the holding slot both occupied any further byte is lost and flags overflow
  task automatic model_byte(input logic [7:0] b);
    logic [VW-1:0] v;
    if (exp_q.size() >= 2) begin
      exp_ovf = 1'b1;
      return;
    end
    part_q.push_back(b);
    if (part_q.size() == BYTES_PER_VEC) begin
      v = '0;
      for (int i = 0; i < BYTES_PER_VEC; i++) v[i*8 +: 8] = part_q[i];
      exp_q.push_back(v);
      part_q.delete();
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // tail=0 returns as soon as a good stop bit starts, so the caller can watch the output
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit tail);
    if (stop_ok && par_ok) model_byte(b);
    if (!stop_ok) exp_ferr = 1'b1;
    if (!par_ok) exp_perr = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    uart_rxd = stop_ok;
    if (!stop_ok || tail) begin
      drive_bit(stop_ok);
      drive_bit(1'b1);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    part_q.delete();
  endtask

  // scoreboard monitor: every handshake consumes the oldest expected vector
  always @(negedge clk) begin
    if (reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_vector: got %h expected none", vector_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("vector", vector_out, mon_exp);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int r;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_vector", vector_out, '0);
    check("rst_valid", valid_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ready_in = 1'b1;
    idle_cycles(4 * CPB);

    // two-cycle low glitch must produce nothing
    uart_rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_cycles(3 * CPB);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_valid", valid_out, 0);

    // basic vector, 1-cycle valid pulse with ready high
    send_frame(8'h34, 1, 1, 1);
    send_frame(8'h12, 1, 1, 1);
    send_frame(8'h78, 1, 1, 1);
    send_frame(8'h56, 1, 1, 0);
    for (int i = 0; i < 6 * CPB && !valid_out; i++) @(negedge clk);
    check("basic_valid_seen", valid_out, 1);
    check("basic_vector", vector_out, 32'h5678_1234);
    @(negedge clk);
    check("basic_pulse_width", valid_out, 0);
    @(posedge clk);
    #1;
    idle_cycles(2 * CPB);

    // back-pressure: two vectors then one overflowing byte
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'(8'h11 * (i + 1)), 1, 1, 1);
    first_vec  = exp_q[0];
    second_vec = exp_q[1];
    send_frame(8'hEE, 1, 1, 1);
    check("bp_overflow", overflow, 1);
    check("bp_valid_held", valid_out, 1);
    check("bp_vector_stable", vector_out, first_vec);
    ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_second_valid", valid_out, 1);
    check("bp_second_vector", vector_out, second_vec);
    @(posedge clk);
    #1;
    idle_cycles(CPB);

    // bad stop bit: byte dropped, following bytes still align
    send_frame(8'hA5, 0, 1, 1);
    check("ferr_flag", frame_err, 1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1, 1, 1);

    // flush discards a partial vector
    send_frame(8'h01, 1, 1, 1);
    send_frame(8'h02, 1, 1, 1);
    pulse_flush();
    send_frame(8'hAA, 1, 1, 1);
    send_frame(8'hBB, 1, 1, 1);
    send_frame(8'hCC, 1, 1, 0);
    idle_cycles(CPB);
    send_frame(8'hDD, 1, 1, 0);
    for (int i = 0; i < 6 * CPB && !valid_out; i++) @(negedge clk);
    check("flush_vector", vector_out, 32'hDDCC_BBAA);
    @(posedge clk);
    #1;
    idle_cycles(2 * CPB);

    // randomized traffic with flushes, framing errors and gaps
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) pulse_flush();
      rb = 8'($urandom);
      send_frame(rb, r != 1, 1, 1);
      idle_cycles($urandom_range(0, 3 * CPB));
    end
    check("rand_pending", 32'(exp_q.size()), 0);

    // reset in the middle of a frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset = 1'b0;
    uart_rxd = 1'b1;
    part_q.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_vector", vector_out, '0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycles(2 * CPB);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1, 1, 1);

`ifdef PARITY_EN
    send_frame(8'h01, 1, 0, 1);
    check("parity_flag", parity_err, 1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1, 1, 1);
`endif

    idle_cycles(4 * CPB);
    check("drain_pending", 32'(exp_q.size()), 0);
    check("final_overflow", overflow, exp_ovf);
    check("final_frame_err", frame_err, exp_ferr);
    check("final_parity_err", parity_err, exp_perr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
